// File: rtl/counter_mod.sv
// Parametrised up/down modulo counter with parallel load, one-shot mode,
// registered overflow/underflow pulses and a done level for timer/event uses.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   RUN   | counting; count_en advances toward/through the terminal
//   DONE  | one-shot run finished; count frozen until clr/load/rst
module counter_mod #(
   parameter int unsigned            WIDTH     = 8,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             count_en,
   input  logic             count_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic [WIDTH-1:0] mod_val,
   input  logic             one_shot,
   output logic [WIDTH-1:0] count,
   output logic             overflow,
   output logic             underflow,
   output logic             done
);

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_done;

   logic             w_up_term;
   logic             w_dn_term;
   logic             w_dn_above;

   // >= rather than == so an out-of-range load still terminates going up.
   assign w_up_term  = (r_count >= mod_val);
   assign w_dn_term  = (r_count == '0);
   assign w_dn_above = (r_count > mod_val);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_count     <= RESET_VAL;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         if (count_clr) begin
            r_count <= '0;
            r_state <= RUN;
            r_done  <= 1'b0;
         end else if (load) begin
            r_count <= load_val;
            r_state <= RUN;
            r_done  <= 1'b0;
         end else if (count_en && (r_state == RUN)) begin
            if (!dir) begin
               if (w_up_term) begin
                  r_overflow <= 1'b1;
                  if (one_shot) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_count <= '0;
                  end
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end else begin
               if (w_dn_term) begin
                  r_underflow <= 1'b1;
                  if (one_shot) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_count <= mod_val;
                  end
               end else if (w_dn_above) begin
                  r_count <= mod_val;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
         end
      end
   end

   assign count     = r_count;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;
   assign done      = r_done;

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: full range, modulo, down/out-of-range,
// one-shot, priority, and mod_val = 0 cases with hand-computed expectations.
module tb_counter_mod;

   localparam int unsigned      WIDTH = 8;
   localparam logic [WIDTH-1:0] RVAL  = 8'hA5;

   logic             clk = 1'b0;
   logic             rst;
   logic             count_en;
   logic             count_clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             dir;
   logic [WIDTH-1:0] mod_val;
   logic             one_shot;
   logic [WIDTH-1:0] count;
   logic             overflow;
   logic             underflow;
   logic             done;

   int n_tests = 0;
   int n_fail  = 0;

   counter_mod #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
      .clk       (clk),
      .rst       (rst),
      .count_en  (count_en),
      .count_clr (count_clr),
      .load      (load),
      .load_val  (load_val),
      .dir       (dir),
      .mod_val   (mod_val),
      .one_shot  (one_shot),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] c, input logic o,
                          input logic u, input logic d);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".ovf"},   32'(overflow), 32'(o));
      chk({tag, ".udf"},   32'(underflow), 32'(u));
      chk({tag, ".done"},  32'(done), 32'(d));
   endtask

   initial begin
      rst = 1'b1; count_en = 1'b0; count_clr = 1'b0; load = 1'b0;
      load_val = '0; dir = 1'b0; mod_val = 8'hFF; one_shot = 1'b0;
      step(); step();
      chk_all("reset", RVAL, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // full range: 256 enables from 0 wrap to 0 with one overflow
      count_clr = 1'b1; step(); count_clr = 1'b0;
      chk_all("clr", 8'h00, 1'b0, 1'b0, 1'b0);
      count_en = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         step();
         chk("full.count", 32'(count), 32'(i % 256));
         chk("full.ovf", 32'(overflow), 32'(i == 256));
      end
      step();
      chk_all("full.after", 8'h01, 1'b0, 1'b0, 1'b0);
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      chk_all("midrst", RVAL, 1'b0, 1'b0, 1'b0);
      // reset on the wrapping edge suppresses the pulse
      count_en = 1'b0; load = 1'b1; load_val = 8'hFF; step(); load = 1'b0;
      count_en = 1'b1; rst = 1'b1; step(); rst = 1'b0; count_en = 1'b0;
      chk_all("rst_pend", RVAL, 1'b0, 1'b0, 1'b0);

      // modulo 10 up
      mod_val = 8'd9; count_clr = 1'b1; step(); count_clr = 1'b0;
      count_en = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         step();
         chk("mod10.count", 32'(count), 32'(k % 10));
         chk("mod10.ovf", 32'(overflow), 32'((k % 10) == 0));
      end

      // down from out-of-range
      count_en = 1'b0; load = 1'b1; load_val = 8'h50; mod_val = 8'h20; dir = 1'b1;
      step(); load = 1'b0;
      chk_all("dn.load", 8'h50, 1'b0, 1'b0, 1'b0);
      count_en = 1'b1; step();
      chk_all("dn.clamp", 8'h20, 1'b0, 1'b0, 1'b0);
      for (int k = 31; k >= 0; k--) begin
         step();
         chk("dn.count", 32'(count), 32'(k));
         chk("dn.udf", 32'(underflow), 32'(0));
      end
      step();
      chk_all("dn.wrap", 8'h20, 1'b0, 1'b1, 1'b0);
      step();
      chk_all("dn.next", 8'h1F, 1'b0, 1'b0, 1'b0);

      // one-shot up
      count_en = 1'b0; dir = 1'b0; one_shot = 1'b1; mod_val = 8'd3;
      count_clr = 1'b1; step(); count_clr = 1'b0;
      count_en = 1'b1;
      step(); chk_all("os.1", 8'd1, 1'b0, 1'b0, 1'b0);
      step(); chk_all("os.2", 8'd2, 1'b0, 1'b0, 1'b0);
      step(); chk_all("os.3", 8'd3, 1'b0, 1'b0, 1'b0);
      step(); chk_all("os.term", 8'd3, 1'b1, 1'b0, 1'b1);
      one_shot = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk_all("os.hold", 8'd3, 1'b0, 1'b0, 1'b1);
      end
      load = 1'b1; load_val = 8'd1; step(); load = 1'b0;
      chk_all("os.load", 8'd1, 1'b0, 1'b0, 1'b0);
      step(); chk_all("os.resume", 8'd2, 1'b0, 1'b0, 1'b0);

      // one-shot down
      count_en = 1'b0; dir = 1'b1; one_shot = 1'b1; mod_val = 8'd2;
      load = 1'b1; load_val = 8'd1; step(); load = 1'b0;
      count_en = 1'b1;
      step(); chk_all("osd.0", 8'd0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("osd.term", 8'd0, 1'b0, 1'b1, 1'b1);
      step(); chk_all("osd.hold", 8'd0, 1'b0, 1'b0, 1'b1);

      // priority
      count_en = 1'b0; dir = 1'b0; one_shot = 1'b0; mod_val = 8'hFF;
      load = 1'b1; load_val = 8'd7; step();
      chk_all("pri.seed", 8'd7, 1'b0, 1'b0, 1'b0);
      count_clr = 1'b1; count_en = 1'b1; load_val = 8'h33; step();
      chk_all("pri.clr", 8'h00, 1'b0, 1'b0, 1'b0);
      count_clr = 1'b0; step();
      chk_all("pri.load", 8'h33, 1'b0, 1'b0, 1'b0);
      load = 1'b0; step();
      chk_all("pri.en", 8'h34, 1'b0, 1'b0, 1'b0);

      // degenerate mod_val = 0
      count_en = 1'b0; mod_val = 8'd0; count_clr = 1'b1; step(); count_clr = 1'b0;
      count_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_all("deg.up", 8'd0, 1'b1, 1'b0, 1'b0);
      end
      dir = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all("deg.dn", 8'd0, 1'b0, 1'b1, 1'b0);
      end
      count_en = 1'b0; step();
      chk_all("deg.idle", 8'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
